// File: rtl/uart_pkg.sv
// UART receive package: FSM state encoding and default frame geometry.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_e;

    localparam int UART_DATA_BITS_DEF  = 8;
    localparam int UART_OVERSAMPLE_DEF = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a one-cycle falling-edge strobe.
module uart_rx_sync (
    input  logic tx_clk,
    input  logic reset,
    input  logic rx_in,
    output logic rx_s,
    output logic fall_edge
);

    logic rx_meta;
    logic rx_prev;

    // Idle line is high, so every flop comes out of reset at 1.
    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign fall_edge = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: oversampled start/data/stop capture onto a valid/ready port.
// Optional even-parity bit and parity_err output are enabled by UART_RX_PARITY_EN.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
    parameter int DATA_BITS  = UART_DATA_BITS_DEF
) (
    input  logic                 tx_clk,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    localparam uart_rx_state_e AFTER_DATA = PARITY;
`else
    localparam uart_rx_state_e AFTER_DATA = STOP;
`endif

    uart_rx_state_e       state;
    uart_rx_state_e       state_d;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 rx_s;
    logic                 fall_edge;
    logic                 cnt_end;
    logic                 stop_hit;
    logic                 good;
    logic                 par_bad;

    uart_rx_sync u_sync (
        .tx_clk    (tx_clk),
        .reset     (reset),
        .rx_in     (rx_in),
        .rx_s      (rx_s),
        .fall_edge (fall_edge)
    );

    assign cnt_end = (cnt == CNT_END);
    assign busy    = (state != IDLE);

    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        stop_hit = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall_edge)
                    state_d = START;
            end
            START: begin
                // High at mid start bit means the edge was a glitch.
                if (cnt == CNT_MID)
                    state_d = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (cnt_end && bit_idx == BIT_LAST)
                    state_d = AFTER_DATA;
            end
            PARITY: begin
                if (cnt_end)
                    state_d = STOP;
            end
            STOP: begin
                if (cnt_end) begin
                    state_d  = IDLE;
                    stop_hit = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            par_bit <= 1'b0;
        end else if (state == PARITY && cnt_end) begin
            par_bit <= rx_s;
        end
    end

    // Even parity: the parity bit equals the XOR of the data bits.
    assign par_bad = par_bit ^ (^shift);
`else
    assign par_bad = 1'b0;
`endif

    assign good = stop_hit & rx_s & ~par_bad;

    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (state_d != state || state == IDLE || cnt_end)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);

            if (state != DATA)
                bit_idx <= '0;
            else if (cnt_end)
                bit_idx <= bit_idx + BW'(1);

            if (state == DATA && cnt_end)
                shift[bit_idx] <= rx_s;

            rx_done   <= 1'b0;
            frame_err <= stop_hit & ~rx_s;
            overrun   <= good & rx_valid & ~rx_ready;
`ifdef UART_RX_PARITY_EN
            parity_err <= stop_hit & par_bad;
`endif

            // A load in the handshake cycle keeps rx_valid high.
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            if (good && (!rx_valid || rx_ready)) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
                rx_done  <= 1'b1;
            end
        end
    end

endmodule
